// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM states, coin values, price table.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_e;

    localparam int unsigned COIN_W  = 3;
    localparam int unsigned PRICE_W = 3;
    localparam int unsigned ID_W    = 2;

    localparam logic [COIN_W-1:0] COIN_N_VAL = 3'd1;
    localparam logic [COIN_W-1:0] COIN_D_VAL = 3'd2;
    localparam logic [COIN_W-1:0] COIN_Q_VAL = 3'd5;

    // Product price in nickels.
    function automatic logic [PRICE_W-1:0] price_of(input logic [ID_W-1:0] id);
        logic [PRICE_W-1:0] p;
        case (id)
            2'd0:    p = 3'd3;
            2'd1:    p = 3'd4;
            2'd2:    p = 3'd5;
            default: p = 3'd7;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/vend_timeout_timer.sv
// Inactivity counter for the COLLECT state; last_o flags that TIMEOUT_CYC-1 idle cycles have elapsed,
// so one more idle cycle completes the timeout. Only built with VEND_TIMEOUT_EN.
module vend_timeout_timer #(
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic run_i,
    input  logic reload_i,
    output logic last_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q;

    // Count idle cycles while running; saturate at the last value.
    always_comb begin
        cnt_d = cnt_q;
        if (!run_i || reload_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= (cnt_d == CNT_LAST);
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/vend_ctrl.sv
// Vending machine controller: coin collection, product dispense and nickel-by-nickel change.
// Optional inactivity auto-refund in COLLECT is enabled by defining VEND_TIMEOUT_EN.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W    = 5,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_n,
    input  logic                coin_d,
    input  logic                coin_q,
    input  logic                sel_valid,
    input  logic [ID_W-1:0]     sel_id,
    input  logic                coin_return,
    output logic                dispense_req,
    output logic [ID_W-1:0]     dispense_id,
    input  logic                dispense_ack,
    output logic                change_req,
    input  logic                change_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                coin_reject,
    output logic                insufficient
);

    localparam int unsigned SUM_W = CREDIT_W + 1;

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [ID_W-1:0]     disp_id_q, disp_id_d;
    logic                disp_req_q, chg_req_q, busy_q, reject_q, insuff_q;
    logic                insuff_d;

    logic                coin_any_c, coin_extra_c, coin_ok_c, reject_c, timeout_c;
    logic [COIN_W-1:0]   coin_val_c;
    logic [SUM_W-1:0]    sum_c;

    // Coin priority q > d > n; lower-priority simultaneous coins are rejected.
    always_comb begin
        coin_val_c   = '0;
        coin_extra_c = 1'b0;
        if (coin_q) begin
            coin_val_c   = COIN_Q_VAL;
            coin_extra_c = coin_d | coin_n;
        end else if (coin_d) begin
            coin_val_c   = COIN_D_VAL;
            coin_extra_c = coin_n;
        end else if (coin_n) begin
            coin_val_c   = COIN_N_VAL;
        end
    end

    assign coin_any_c = coin_n | coin_d | coin_q;
    assign sum_c      = {1'b0, credit_q} + SUM_W'(coin_val_c);
    assign coin_ok_c  = coin_any_c && !sum_c[CREDIT_W]
                        && ((state_q == IDLE) || (state_q == COLLECT));
    assign reject_c   = coin_extra_c || (coin_any_c && !coin_ok_c);

`ifdef VEND_TIMEOUT_EN
    logic tmo_last;

    vend_timeout_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .run_i    (state_q == COLLECT),
        .reload_i (coin_any_c || sel_valid),
        .last_o   (tmo_last)
    );

    assign timeout_c = (state_q == COLLECT) && !coin_any_c && !sel_valid && tmo_last;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout_c          = 1'b0;
`endif

    // Next-state and credit update.
    always_comb begin
        state_d   = state_q;
        credit_d  = credit_q;
        disp_id_d = disp_id_q;
        insuff_d  = 1'b0;

        if (coin_ok_c) begin
            credit_d = sum_c[CREDIT_W-1:0];
        end

        case (state_q)
            IDLE: begin
                if (coin_ok_c) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                // Selection is judged on credit before any same-cycle coin.
                if (coin_return) begin
                    state_d = CHANGE;
                end else if (sel_valid) begin
                    if (credit_q >= CREDIT_W'(price_of(sel_id))) begin
                        state_d   = VEND;
                        disp_id_d = sel_id;
                    end else begin
                        insuff_d = 1'b1;
                    end
                end else if (timeout_c) begin
                    state_d = CHANGE;
                end
            end
            VEND: begin
                if (dispense_ack) begin
                    credit_d = credit_q - CREDIT_W'(price_of(disp_id_q));
                    state_d  = (credit_d != '0) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                if (credit_q == '0) begin
                    state_d = IDLE;
                end else if (change_ack) begin
                    credit_d = credit_q - CREDIT_W'(1);
                    if (credit_d == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they align with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            credit_q   <= '0;
            disp_id_q  <= '0;
            disp_req_q <= 1'b0;
            chg_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            reject_q   <= 1'b0;
            insuff_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            disp_id_q  <= disp_id_d;
            disp_req_q <= (state_d == VEND);
            chg_req_q  <= (state_d == CHANGE);
            busy_q     <= (state_d == VEND) || (state_d == CHANGE);
            reject_q   <= reject_c;
            insuff_q   <= insuff_d;
        end
    end

    assign credit       = credit_q;
    assign dispense_id  = disp_id_q;
    assign dispense_req = disp_req_q;
    assign change_req   = chg_req_q;
    assign busy         = busy_q;
    assign coin_reject  = reject_q;
    assign insufficient = insuff_q;

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 Parameter CREDIT_W, default 5, SHALL set the credit register width in nickels (max credit 2^CREDIT_W-1).
REQ-002 Parameter TIMEOUT_CYC, default 1000, SHALL set the inactivity timeout in clk cycles (used only with VEND_TIMEOUT_EN).
REQ-003 Port clk, input, 1, SHALL be the clock; all state updates on the posedge.
REQ-004 Port reset, input, 1, SHALL be the asynchronous, active-high reset.
REQ-005 Ports coin_n / coin_d / coin_q, input, 1 each, SHALL be single-cycle coin pulses worth 1 / 2 / 5 nickels.
REQ-006 Ports sel_valid (1) and sel_id (2), input, SHALL be the product-select strobe and product index.
REQ-007 Port coin_return, input, 1, SHALL be the refund request pulse.
REQ-008 Ports dispense_req (out, 1), dispense_id (out, 2), dispense_ack (in, 1) SHALL form the product-dispense handshake.
REQ-009 Ports change_req (out, 1) and change_ack (in, 1) SHALL form the change handshake; each ack cycle pays one nickel.
REQ-010 Ports credit (out, CREDIT_W), busy (out, 1), coin_reject (out, 1), insufficient (out, 1) SHALL report status.

Function
REQ-011 The FSM SHALL have states IDLE, COLLECT, VEND, CHANGE.
REQ-012 IDLE->COLLECT on any accepted coin; COLLECT->VEND on an affordable selection; COLLECT->CHANGE on coin_return; VEND->CHANGE on dispense_ack if remaining credit > 0, else VEND->IDLE; CHANGE->IDLE when credit reaches 0.
REQ-013 Prices in nickels SHALL be: id0=3, id1=4, id2=5, id3=7.
REQ-014 Coins SHALL be accepted only in IDLE/COLLECT; they SHALL be added to credit on the same edge; credit is visible the next cycle.
REQ-015 Simultaneous coin pulses: priority q>d>n; the others SHALL be rejected.
REQ-016 A coin whose addition exceeds 2^CREDIT_W-1, or any coin in VEND/CHANGE, SHALL be rejected: credit unchanged, coin_reject high for exactly one cycle on the next cycle.
REQ-017 A selection SHALL be evaluated against the pre-coin credit register. If a coin arrives in the same cycle, the coin is still credited.
REQ-018 A selection with credit < price SHALL leave the state unchanged and pulse insufficient for one cycle. Selections outside COLLECT SHALL be ignored.
REQ-019 sel_valid and coin_return in the same cycle: coin_return SHALL win.
REQ-020 In VEND, dispense_req SHALL be held high with dispense_id stable until dispense_ack. On the ack edge, credit SHALL decrease by the price and dispense_req SHALL drop the next cycle.
REQ-021 In CHANGE, change_req SHALL be high. Each cycle with change_ack high SHALL decrement credit by 1. change_req SHALL drop in the cycle credit reads 0.
REQ-022 busy SHALL be high in VEND and CHANGE.
REQ-023 Acks received outside their own state SHALL be ignored.

Reset
REQ-024 While reset is asserted, the state SHALL be IDLE, credit 0, and every output 0, including mid-handshake; no refund of the lost credit.

Configuration
REQ-025 With VEND_TIMEOUT_EN defined, TIMEOUT_CYC consecutive cycles in COLLECT with no coin and no sel_valid SHALL force COLLECT->CHANGE (auto-refund). Any coin or sel_valid SHALL reload the counter.
REQ-026 Without VEND_TIMEOUT_EN, no timeout counter SHALL exist, and COLLECT SHALL persist indefinitely.

Structure
REQ-027 Package vend_pkg SHALL hold the state enum, coin values (1/2/5), and the price table.
REQ-028 The timeout counter SHALL be sub-module vend_timeout_timer, instantiated only under VEND_TIMEOUT_EN.

Verification
REQ-029 Stimulus: d, n, then sel_id=0. Required: credit 3, VEND, dispense_id=0; after ack, credit 0 and IDLE, no change_req.
REQ-030 Stimulus: q, then sel_id=1. Required: dispense, then credit 1, change_req for one ack, then IDLE.
REQ-031 Stimulus: n, sel_id=2. Required: insufficient pulse, state COLLECT, credit 1; then coin_return gives 1 change ack, then IDLE.
REQ-032 Stimulus: credit 30, then q. Required: coin_reject pulse, credit 30. Stimulus: q+d+n in one cycle from 0. Required: credit 5.
REQ-033 Stimulus: reset asserted while dispense_req is high. Required: all outputs 0 and credit 0 immediately, asynchronously.
REQ-034 With VEND_TIMEOUT_EN and TIMEOUT_CYC=10: d, then idle 10 cycles. Required: CHANGE and 2 change acks; a coin in cycle 9 restarts the count.
